// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU classes,
// mux selects, FSM state encoding and the per-state control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_LUI   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_R     = 4'd7,
        ST_WB_I     = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    // Registered Moore part of the outputs; ir_write is purely the FETCH handshake.
    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_t;

    // States in which the controller waits on memory and the timer runs.
    function automatic logic is_wait_state(state_t st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

    // Control word for a state; op only matters for EXEC_I and BRANCH.
    function automatic ctrl_t ctrl_for(state_t st, logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
                c.alu_op    = ALU_ADD;
                c.pc_src    = PC_SRC_ALU;
            end
            ST_DECODE: begin
                c.alu_src_b = SRC_B_IMM_SH2;
                c.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_RT;
                c.alu_op    = ALU_RTYPE;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                case (op)
                    OP_ORI:  c.alu_op = ALU_OR;
                    OP_LUI:  c.alu_op = ALU_LUI;
                    default: c.alu_op = ALU_ADD;
                endcase
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_WB_R: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            ST_WB_I: c.reg_write = 1'b1;
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_RT;
                c.alu_op    = ALU_SUB;
                c.pc_src    = PC_SRC_ALU_OUT;
                c.branch_eq = (op == OP_BEQ);
                c.branch_ne = (op == OP_BNE);
            end
            ST_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PC_SRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction/memory handshake and datapath control bundle of the controller.
interface multicycle_control_if #(
    parameter int ALU_OP_W = 3
);
    logic [5:0]          opcode_i;
    logic                mem_ready_i;
    logic                pc_write_o;
    logic                branch_eq_o;
    logic                branch_ne_o;
    logic                ir_write_o;
    logic                i_or_d_o;
    logic                mem_read_o;
    logic                mem_write_o;
    logic                mem_to_reg_o;
    logic                reg_dst_o;
    logic                reg_write_o;
    logic                alu_src_a_o;
    logic [1:0]          alu_src_b_o;
    logic [1:0]          pc_src_o;
    logic [ALU_OP_W-1:0] alu_op_o;
    logic [3:0]          state_o;
    logic                illegal_o;
    logic                timeout_o;

    modport master (
        output opcode_i, mem_ready_i,
        input  pc_write_o, branch_eq_o, branch_ne_o, ir_write_o, i_or_d_o,
               mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o, state_o,
               illegal_o, timeout_o
    );

    modport slave (
        input  opcode_i, mem_ready_i,
        output pc_write_o, branch_eq_o, branch_ne_o, ir_write_o, i_or_d_o,
               mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, pc_src_o, alu_op_o, state_o,
               illegal_o, timeout_o
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter. expired flags the cycle on which another
// not-ready cycle would make MEM_TIMEOUT wait cycles; ready that cycle wins.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    // Saturating up-count of not-ready cycles, cleared on entry to a wait state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !ready && (count != 8'hff)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = count_en && !ready && (count >= LIMIT);
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory wait timeout and
// sticky illegal/timeout traps.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.slave bus
);
    state_t state_q;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   illegal_q;
    logic   timeout_q;
    logic   in_wait;
    logic   wait_clear;
    logic   expired;
    logic   fetch_grant;

    assign in_wait    = is_wait_state(state_q);
    assign wait_clear = is_wait_state(state_nxt) && (state_nxt != state_q);

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .count_en(in_wait),
        .ready   (bus.mem_ready_i),
        .expired (expired)
    );

    // Next-state decode; memory waits fall into TRAP when the timer expires.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready_i) state_nxt = ST_DECODE;
                else if (expired)    state_nxt = ST_TRAP;
            end
            ST_DECODE: begin
                case (bus.opcode_i)
                    OP_RTYPE:              state_nxt = ST_EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI: state_nxt = ST_EXEC_I;
                    OP_LW, OP_SW:          state_nxt = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:        state_nxt = ST_BRANCH;
                    OP_J:                  state_nxt = ST_JUMP;
                    default:               state_nxt = ST_TRAP;
                endcase
            end
            ST_EXEC_R:   state_nxt = ST_WB_R;
            ST_EXEC_I:   state_nxt = ST_WB_I;
            ST_MEM_ADDR: state_nxt = (bus.opcode_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (bus.mem_ready_i) state_nxt = ST_WB_MEM;
                else if (expired)    state_nxt = ST_TRAP;
            end
            ST_MEM_WR: begin
                if (bus.mem_ready_i) state_nxt = ST_FETCH;
                else if (expired)    state_nxt = ST_TRAP;
            end
            ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_nxt = ST_FETCH;
            ST_TRAP:     state_nxt = ST_TRAP;
            default:     state_nxt = ST_TRAP;
        endcase
    end

    // State, registered control word and sticky trap causes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ctrl_q    <= ctrl_for(ST_FETCH, OP_RTYPE);
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= ctrl_for(state_nxt, bus.opcode_i);
            if (state_nxt == ST_TRAP && state_q == ST_DECODE) illegal_q <= 1'b1;
            if (state_nxt == ST_TRAP && in_wait)              timeout_q <= 1'b1;
        end
    end

    // The instruction fetch handshake is the only Mealy path; held off during reset.
    assign fetch_grant = (state_q == ST_FETCH) && bus.mem_ready_i && !reset;

    assign bus.pc_write_o   = ctrl_q.pc_write | fetch_grant;
    assign bus.ir_write_o   = fetch_grant;
    assign bus.branch_eq_o  = ctrl_q.branch_eq;
    assign bus.branch_ne_o  = ctrl_q.branch_ne;
    assign bus.i_or_d_o     = ctrl_q.i_or_d;
    assign bus.mem_read_o   = ctrl_q.mem_read;
    assign bus.mem_write_o  = ctrl_q.mem_write;
    assign bus.mem_to_reg_o = ctrl_q.mem_to_reg;
    assign bus.reg_dst_o    = ctrl_q.reg_dst;
    assign bus.reg_write_o  = ctrl_q.reg_write;
    assign bus.alu_src_a_o  = ctrl_q.alu_src_a;
    assign bus.alu_src_b_o  = ctrl_q.alu_src_b;
    assign bus.pc_src_o     = ctrl_q.pc_src;
    assign bus.alu_op_o     = ALU_OP_W'(ctrl_q.alu_op);
    assign bus.state_o      = state_q;
    assign bus.illegal_o    = illegal_q;
    assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Scenario bench for multicycle_control (MEM_TIMEOUT = 4).
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    multicycle_control_if ifc ();

    multicycle_control #(.ALU_OP_W(3), .MEM_TIMEOUT(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        state_t     st;
        logic       ill;
        logic       to;
    } stim_t;

    logic [23:0] sb[$];
    int n_vec  = 0;
    int n_miss = 0;

    // Expected outputs straight from the per-state output table.
    function automatic logic [23:0] exp_vec(state_t st, logic [5:0] op, logic rdy,
                                            logic ill, logic to);
        logic pcw, beq, bne, irw, iod, mrd, mwr, m2r, rdst, rw, sa;
        logic [1:0] sbv, ps;
        logic [2:0] ao;
        {pcw, beq, bne, irw, iod, mrd, mwr, m2r, rdst, rw, sa} = '0;
        sbv = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            ST_FETCH:    begin mrd = 1; sbv = 2'b01; ao = 3'b100; pcw = rdy; irw = rdy; end
            ST_DECODE:   begin sbv = 2'b11; ao = 3'b100; end
            ST_EXEC_R:   begin sa = 1; ao = 3'b111; end
            ST_EXEC_I:   begin
                sa = 1; sbv = 2'b10;
                ao = (op == 6'h0d) ? 3'b010 : (op == 6'h0f) ? 3'b001 : 3'b100;
            end
            ST_MEM_ADDR: begin sa = 1; sbv = 2'b10; ao = 3'b100; end
            ST_MEM_RD:   begin mrd = 1; iod = 1; end
            ST_MEM_WR:   begin mwr = 1; iod = 1; end
            ST_WB_R:     begin rdst = 1; rw = 1; end
            ST_WB_I:     rw = 1;
            ST_WB_MEM:   begin rw = 1; m2r = 1; end
            ST_BRANCH:   begin sa = 1; ao = 3'b011; ps = 2'b01; beq = (op == 6'h04); bne = (op == 6'h05); end
            ST_JUMP:     begin pcw = 1; ps = 2'b10; end
            default:     ;
        endcase
        return {st, pcw, beq, bne, irw, iod, mrd, mwr, m2r, rdst, rw, sa, sbv, ps, ao, ill, to};
    endfunction

    function automatic logic [23:0] obs();
        return {ifc.state_o, ifc.pc_write_o, ifc.branch_eq_o, ifc.branch_ne_o, ifc.ir_write_o,
                ifc.i_or_d_o, ifc.mem_read_o, ifc.mem_write_o, ifc.mem_to_reg_o, ifc.reg_dst_o,
                ifc.reg_write_o, ifc.alu_src_a_o, ifc.alu_src_b_o, ifc.pc_src_o, ifc.alu_op_o,
                ifc.illegal_o, ifc.timeout_o};
    endfunction

    function automatic stim_t s(logic [5:0] op, logic rdy, state_t st,
                                logic ill = 1'b0, logic to = 1'b0);
        stim_t r;
        r.op = op; r.rdy = rdy; r.st = st; r.ill = ill; r.to = to;
        return r;
    endfunction

    // Drive one cycle's inputs after the falling edge and queue its expectation.
    task automatic step(stim_t x);
        @(negedge clk);
        ifc.opcode_i    = x.op;
        ifc.mem_ready_i = x.rdy;
        sb.push_back(exp_vec(x.st, x.op, x.rdy, x.ill, x.to));
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.mem_ready_i = 1'b0;
        ifc.opcode_i = 6'h00;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stim_t q[$];
        logic [23:0] got, want;
        @(negedge clk);
        reset = 1'b1;
        ifc.mem_ready_i = 1'b1;
        ifc.opcode_i = 6'h00;
        for (int k = 0; k < 2; k++) begin
            #1;
            sb.push_back(exp_vec(ST_FETCH, 6'h00, 1'b0, 1'b0, 1'b0));
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL reset_hold k%0d got=%h want=%h", k, got, want);
            end
            @(posedge clk);
        end
        #1;
        ifc.mem_ready_i = 1'b0;
        reset = 1'b0;
        q = '{s(6'h00, 0, ST_FETCH), s(6'h00, 0, ST_FETCH), s(6'h00, 1, ST_FETCH),
              s(6'h00, 0, ST_DECODE)};
        foreach (q[i]) begin
            step(q[i]);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL reset_release cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_rtype();
        stim_t q[$];
        logic [23:0] got, want;
        apply_reset();
        q = '{s(6'h00, 1, ST_FETCH), s(6'h00, 1, ST_DECODE), s(6'h00, 1, ST_EXEC_R),
              s(6'h00, 1, ST_WB_R), s(6'h00, 0, ST_FETCH)};
        foreach (q[i]) begin
            step(q[i]);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL rtype cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0] ops[3] = '{6'h08, 6'h0d, 6'h0f};
        stim_t q[$];
        logic [23:0] got, want;
        foreach (ops[j]) begin
            apply_reset();
            q = '{s(ops[j], 1, ST_FETCH), s(ops[j], 0, ST_DECODE), s(ops[j], 0, ST_EXEC_I),
                  s(ops[j], 0, ST_WB_I), s(ops[j], 0, ST_FETCH)};
            foreach (q[i]) begin
                step(q[i]);
                got = obs(); want = sb.pop_front(); n_vec++;
                if (got !== want) begin
                    n_miss++;
                    $display("FAIL itype op%h cyc%0d got=%h want=%h", ops[j], i, got, want);
                end
            end
        end
    endtask

    task automatic test_load_wait();
        stim_t q[$];
        logic [23:0] got, want;
        apply_reset();
        q = '{s(6'h23, 1, ST_FETCH), s(6'h23, 1, ST_DECODE), s(6'h23, 0, ST_MEM_ADDR),
              s(6'h23, 0, ST_MEM_RD), s(6'h23, 0, ST_MEM_RD), s(6'h23, 0, ST_MEM_RD),
              s(6'h23, 1, ST_MEM_RD), s(6'h23, 0, ST_WB_MEM), s(6'h23, 0, ST_FETCH)};
        foreach (q[i]) begin
            step(q[i]);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL lw_wait cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_illegal();
        stim_t q[$];
        logic [23:0] got, want;
        apply_reset();
        q = '{s(6'h3f, 1, ST_FETCH), s(6'h3f, 1, ST_DECODE)};
        for (int k = 0; k < 20; k++)
            q.push_back(s(6'h3f, 1'($urandom_range(0, 1)), ST_TRAP, 1'b1, 1'b0));
        foreach (q[i]) begin
            step(q[i]);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL illegal cyc%0d got=%h want=%h", i, got, want);
            end
        end
        apply_reset();
        step(s(6'h00, 0, ST_FETCH));
        got = obs(); want = sb.pop_front(); n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL illegal_cleared got=%h want=%h", got, want);
        end
    endtask

    task automatic test_timeout();
        stim_t q[$];
        logic [23:0] got, want;
        apply_reset();
        q = '{s(6'h2b, 1, ST_FETCH), s(6'h2b, 0, ST_DECODE), s(6'h2b, 0, ST_MEM_ADDR),
              s(6'h2b, 0, ST_MEM_WR), s(6'h2b, 0, ST_MEM_WR), s(6'h2b, 0, ST_MEM_WR),
              s(6'h2b, 0, ST_MEM_WR), s(6'h2b, 1, ST_TRAP, 0, 1), s(6'h2b, 1, ST_TRAP, 0, 1),
              s(6'h2b, 0, ST_TRAP, 0, 1)};
        foreach (q[i]) begin
            step(q[i]);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL timeout cyc%0d got=%h want=%h", i, got, want);
            end
        end
        apply_reset();
        q = '{s(6'h2b, 1, ST_FETCH), s(6'h2b, 0, ST_DECODE), s(6'h2b, 0, ST_MEM_ADDR),
              s(6'h2b, 0, ST_MEM_WR), s(6'h2b, 0, ST_MEM_WR), s(6'h2b, 0, ST_MEM_WR),
              s(6'h2b, 1, ST_MEM_WR), s(6'h2b, 0, ST_FETCH)};
        foreach (q[i]) begin
            step(q[i]);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL ready_at_limit cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0] ops[3] = '{6'h04, 6'h05, 6'h02};
        stim_t q[$];
        logic [23:0] got, want;
        foreach (ops[j]) begin
            apply_reset();
            q = '{s(ops[j], 1, ST_FETCH), s(ops[j], 0, ST_DECODE),
                  s(ops[j], 0, (ops[j] == 6'h02) ? ST_JUMP : ST_BRANCH), s(ops[j], 0, ST_FETCH)};
            foreach (q[i]) begin
                step(q[i]);
                got = obs(); want = sb.pop_front(); n_vec++;
                if (got !== want) begin
                    n_miss++;
                    $display("FAIL branch_jump op%h cyc%0d got=%h want=%h", ops[j], i, got, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        logic [23:0] got, want;
        apply_reset();
        q = '{s(6'h00, 1, ST_FETCH), s(6'h00, 1, ST_DECODE), s(6'h00, 1, ST_EXEC_R),
              s(6'h00, 1, ST_WB_R), s(6'h23, 1, ST_FETCH), s(6'h23, 1, ST_DECODE),
              s(6'h23, 1, ST_MEM_ADDR), s(6'h23, 1, ST_MEM_RD), s(6'h23, 1, ST_WB_MEM),
              s(6'h23, 0, ST_FETCH)};
        foreach (q[i]) begin
            step(q[i]);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL back_to_back cyc%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        stim_t q[$];
        logic [23:0] got, want;
        apply_reset();
        q = '{s(6'h2b, 1, ST_FETCH), s(6'h2b, 0, ST_DECODE), s(6'h2b, 0, ST_MEM_ADDR),
              s(6'h2b, 0, ST_MEM_WR)};
        foreach (q[i]) begin
            step(q[i]);
            got = obs(); want = sb.pop_front(); n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL mid_reset_pre cyc%0d got=%h want=%h", i, got, want);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(exp_vec(ST_FETCH, 6'h2b, 1'b0, 1'b0, 1'b0));
        got = obs(); want = sb.pop_front(); n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL mid_reset_async got=%h want=%h", got, want);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        step(s(6'h2b, 0, ST_FETCH));
        got = obs(); want = sb.pop_front(); n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL mid_reset_after got=%h want=%h", got, want);
        end
    endtask

    initial begin
        ifc.opcode_i    = 6'h00;
        ifc.mem_ready_i = 1'b0;
        #12;
        test_reset();
        test_rtype();
        test_itype();
        test_load_wait();
        test_illegal();
        test_timeout();
        test_branch_jump();
        test_back_to_back();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1);
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters (name, default, meaning):
- ALU_OP_W, 3, width of alu_op_o.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready_i before trap; range 1..255.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state changes on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- opcode_i, in, 6: instruction opcode from the held instruction register.
- mem_ready_i, in, 1: memory completes the current access this cycle.
- pc_write_o, out, 1: unconditional PC write.
- branch_eq_o, out, 1: PC write if ALU zero.
- branch_ne_o, out, 1: PC write if ALU not zero.
- ir_write_o, out, 1: instruction register load.
- i_or_d_o, out, 1: memory address source; 0 = PC, 1 = ALU output register.
- mem_read_o, out, 1: memory read request.
- mem_write_o, out, 1: memory write request.
- mem_to_reg_o, out, 1: register write-back data from memory.
- reg_dst_o, out, 1: destination register is rd.
- reg_write_o, out, 1: register file write.
- alu_src_a_o, out, 1: ALU A input; 0 = PC, 1 = rs.
- alu_src_b_o, out, 2: ALU B input; 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- pc_src_o, out, 2: PC source; 00 = ALU, 01 = ALU output register, 10 = jump target.
- alu_op_o, out, ALU_OP_W: ALU operation class.
- state_o, out, 4: current state, for debug.
- illegal_o, out, 1: sticky flag, undefined opcode trapped.
- timeout_o, out, 1: sticky flag, memory timeout trapped.

Function
REQ-003 The block is a Moore FSM with these states: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP.
REQ-004 Every output not listed for the current state is 0.
REQ-005 Exception to Moore behaviour: in FETCH only, ir_write_o and pc_write_o equal mem_ready_i (Mealy).
REQ-006 FETCH:
- Outputs: mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=100, pc_src_o=00.
- Stays in FETCH until mem_ready_i=1, then goes to DECODE.
REQ-007 DECODE:
- Outputs: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=100.
- Next state from opcode_i: 0x00 -> EXEC_R; 0x08/0x0d/0x0f -> EXEC_I; 0x23/0x2b -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; any other value -> TRAP with illegal_o set.
REQ-008 EXEC_R:
- Outputs: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=111.
- Goes to WB_R.
REQ-009 WB_R:
- Outputs: reg_dst_o=1, reg_write_o=1.
- Goes to FETCH.
REQ-010 EXEC_I:
- Outputs: alu_src_a_o=1, alu_src_b_o=10.
- alu_op_o: 100 for ADDI, 010 for ORI, 001 for LUI.
- Goes to WB_I.
REQ-011 WB_I:
- Outputs: reg_write_o=1, reg_dst_o=0.
- Goes to FETCH.
REQ-012 MEM_ADDR:
- Outputs: alu_src_a_o=1, alu_src_b_o=10, alu_op_o=100.
- Goes to MEM_RD for 0x23, MEM_WR for 0x2b.
REQ-013 MEM_RD:
- Outputs: mem_read_o=1, i_or_d_o=1.
- Holds until mem_ready_i=1, then goes to WB_MEM.
REQ-014 WB_MEM:
- Outputs: reg_write_o=1, mem_to_reg_o=1.
- Goes to FETCH.
REQ-015 MEM_WR:
- Outputs: mem_write_o=1, i_or_d_o=1.
- Holds until mem_ready_i=1, then goes to FETCH.
REQ-016 BRANCH:
- Outputs: alu_src_a_o=1, alu_src_b_o=00, alu_op_o=011, pc_src_o=01.
- branch_eq_o=1 for opcode 0x04; branch_ne_o=1 for opcode 0x05.
- Goes to FETCH.
REQ-017 JUMP:
- Outputs: pc_write_o=1, pc_src_o=10.
- Goes to FETCH.
REQ-018 opcode_i is sampled only in DECODE, EXEC_I, MEM_ADDR and BRANCH; the instruction register holds it stable outside FETCH.
REQ-019 Wait counter:
- Cleared on entry to FETCH, MEM_RD and MEM_WR.
- Increments on each cycle in those states with mem_ready_i=0.
- Saturates; never wraps.
REQ-020 Timeout:
- If the counter reaches MEM_TIMEOUT with mem_ready_i=0, the next state is TRAP and timeout_o is set.
- mem_ready_i=1 on that same cycle wins: the access completes normally.
REQ-021 TRAP:
- All enables are 0.
- The FSM stays in TRAP until reset.
- illegal_o and timeout_o remain asserted.
REQ-022 A new access starts with mem_ready_i already high: it completes in one cycle (zero wait states).

Reset
REQ-023 Asserting reset immediately, without a clock edge, forces:
- state FETCH, wait counter 0, illegal_o=0, timeout_o=0;
- all write enables low for the duration of reset.
REQ-024 During and after reset, outputs take FETCH values:
- mem_read_o=1, alu_src_b_o=01, alu_op_o=100;
- pc_write_o and ir_write_o follow mem_ready_i only after reset deasserts;
- all other outputs 0; state_o=0.
REQ-025 Reset in mid-operation (for example in MEM_WR) aborts the access; no write enable persists into the reset cycle.

Structure
REQ-026 Shared package mips_ctrl_pkg holds:
- opcode constants;
- alu_op encodings (ADD 100, OR 010, LUI 001, SUB 011, R-type 111);
- alu_src_b and pc_src encodings;
- the state encoding, with FETCH = 0.
REQ-027 The wait counter and its timeout compare form one sub-module, mc_wait_timer: inputs clear, count enable, ready; output expired.

Verification
REQ-028 Bench scenarios:
- Reset, then opcode 0x00 with mem_ready_i=1 -> FETCH, DECODE, EXEC_R, WB_R with reg_write_o=1 and reg_dst_o=1 -> FETCH; 4 cycles total.
- LW (0x23) with memory ready after 3 wait cycles in MEM_RD -> mem_read_o=1 and i_or_d_o=1 held 4 cycles, then WB_MEM with mem_to_reg_o=1.
- Opcode 0x3f in DECODE -> TRAP next cycle, illegal_o=1, all enables 0 for 20 cycles; reset clears it.
- MEM_TIMEOUT=4, SW with mem_ready_i held low -> TRAP after 4 wait cycles, timeout_o=1; a repeat run with ready rising on cycle 4 completes normally.
- BNE (0x05) -> branch_ne_o=1, pc_src_o=01, alu_op_o=011 for exactly 1 cycle; JUMP -> pc_write_o=1, pc_src_o=10.
- Reset asserted in MEM_WR between clock edges -> mem_write_o falls without a clock edge; after release the FSM is in FETCH.
